// File: rtl/adder_pkg.sv
// Shared definitions for the sequenced nibble adder: slice width, FSM states,
// and the result flag payload.
package adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result status flags produced with the final nibble
    typedef struct packed {
        logic carry;
        logic ovf;
    } flags_t;

endpackage : adder_pkg

// File: rtl/adder_seq_ctrl_if.sv
// Operand/result handshake bundle for adder_seq_ctrl.
//   in_valid/in_ready  : operand handshake (in_a, in_b, in_sub)
//   out_valid/out_ready: result handshake (out_sum, out_carry, out_ovf)
//   busy               : unit is computing or holding a result
// master = operand source / result consumer, slave = the adder unit.
interface adder_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, busy
    );
endinterface : adder_seq_ctrl_if

// File: rtl/adder4_cin.sv
// Combinational 4-bit adder slice with carry-in, used to chain nibbles.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   sum  : 4-bit sum
//   cout : carry out of bit 3
module adder4_cin
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    localparam int unsigned EXT_W = NIBBLE_W + 1;

    logic [EXT_W-1:0] total_c;

    // Widen before adding so the carry lands in the top bit
    always_comb begin
        total_c = EXT_W'(a) + EXT_W'(b) + EXT_W'(cin);
    end

    assign sum  = total_c[NIBBLE_W-1:0];
    assign cout = total_c[NIBBLE_W];

endmodule : adder4_cin

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract unit: one 4-bit slice is stepped over
// the operands LSB nibble first, with the carry held in a register between
// steps. Subtract is A + ~B + 1.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of adder_seq_ctrl_if (operand + result handshakes,
//                sum/carry/overflow outputs, busy)
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_seq_ctrl_if.slave   bus
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    flags_t             flags_q, flags_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [NIBBLE_W-1:0] nib_a_c;
    logic [NIBBLE_W-1:0] nib_b_c;
    logic [NIBBLE_W-1:0] nib_sum_c;
    logic                nib_cout_c;

    // Select the current nibble of each operand
    always_comb begin
        nib_a_c = a_q[int'(idx_q) * int'(NIBBLE_W) +: NIBBLE_W];
        nib_b_c = b_q[int'(idx_q) * int'(NIBBLE_W) +: NIBBLE_W];
    end

    adder4_cin u_slice (
        .a    (nib_a_c),
        .b    (nib_b_c),
        .cin  (carry_q),
        .sum  (nib_sum_c),
        .cout (nib_cout_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        flags_d     = flags_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.in_a;
                    b_d        = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d    = bus.in_sub;
                    idx_d      = '0;
                    sum_d      = '0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_RUN: begin
                sum_d[int'(idx_q) * int'(NIBBLE_W) +: NIBBLE_W] = nib_sum_c;
                carry_d = nib_cout_c;
                if (idx_q == IDX_LAST) begin
                    idx_d         = '0;
                    flags_d.carry = nib_cout_c;
                    // Like-signed operands producing an opposite-signed sum
                    flags_d.ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (nib_sum_c[NIBBLE_W-1] != a_q[WIDTH-1]);
                    state_d       = ST_DONE;
                    out_valid_d   = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                idx_d       = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_carry = flags_q.carry;
    assign bus.out_ovf   = flags_q.ovf;
    assign bus.busy      = busy_q;

endmodule : adder_seq_ctrl

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl (WIDTH = 16).
module tb_adder_seq_ctrl;

    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   last_handoff;
    bit   keep_valid;

    adder_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one operation; optionally hold the result under backpressure
    task automatic run_op(input string tag,
                          input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [15:0] exp_sum, input logic exp_c, input logic exp_v,
                          input int bp_cycles, input bit check_gap);
        int n;
        int lat;
        int acc_cyc;
        logic [15:0] held;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.out_ready = (bp_cycles == 0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (check_gap) chk({tag, "_gap"}, 32'(acc_cyc - last_handoff), 32'd1);
        if (!keep_valid) bus.in_valid = 1'b0;
        chk({tag, "_run_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_run_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_run_valid"}, 32'(bus.out_valid), 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.out_valid && lat < 16);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(bus.out_sum), 32'(exp_sum));
        chk({tag, "_carry"}, 32'(bus.out_carry), 32'(exp_c));
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_v));
        if (bp_cycles > 0) begin
            held = bus.out_sum;
            for (int i = 0; i < bp_cycles; i++) begin
                bus.in_a     = 16'($urandom);
                bus.in_b     = 16'($urandom);
                bus.in_sub   = ~bus.in_sub;
                bus.in_valid = ~bus.in_valid;
                @(posedge clk); #1;
                chk({tag, "_bp_sum"}, 32'(bus.out_sum), 32'(held));
                chk({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
                chk({tag, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
            end
            chk({tag, "_bp_carry"}, 32'(bus.out_carry), 32'(exp_c));
            chk({tag, "_bp_ovf"}, 32'(bus.out_ovf), 32'(exp_v));
            bus.in_valid  = keep_valid;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        last_handoff = cyc;
        chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        cyc           = 0;
        n_checks      = 0;
        n_pass        = 0;
        last_handoff  = 0;
        keep_valid    = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_flags", 32'({bus.out_carry, bus.out_ovf}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 1'b0);
        run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        run_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
        run_op("sub_5m7",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0);

        // Backpressure: hold result for 10 cycles with junk on the operand side
        run_op("bp", 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0, 10, 1'b0);
        @(posedge clk); #1;
        chk("bp_no_reaccept_busy", 32'(bus.busy), 32'd0);
        chk("bp_no_reaccept_ready", 32'(bus.in_ready), 32'd1);

        // Reset after two nibbles of an operation
        bus.in_valid = 1'b1;
        bus.in_a     = 16'hAAAA;
        bus.in_b     = 16'h5555;
        bus.in_sub   = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_partial_sum", 32'(bus.out_sum), 32'h00FF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_sum", 32'(bus.out_sum), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 1'b0);

        // Back-to-back with in_valid held high
        keep_valid = 1'b1;
        run_op("b2b_0", 16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0, 0, 1'b0);
        run_op("b2b_1", 16'h1000, 16'h2000, 1'b1, 16'hF000, 1'b0, 1'b0, 0, 1'b1);
        run_op("b2b_2", 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b1);
        keep_valid   = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_adder_seq_ctrl

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-cycle wide add/subtract unit built by sequencing a single 4-bit adder slice over WIDTH/4 nibbles, LSB first, with a registered carry between steps.
- Trades latency for area wherever wide arithmetic is needed infrequently, for example counters and accumulators that are not on the critical path.
- valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
- NIBBLES, WIDTH/4, derived localparam, not overridable; number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op present.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result registers hold a finished result.
- out_ready  input  1  consumer takes the result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; nibble index goes to 0.
  - out_sum, out_carry and out_ovf go to 0; out_valid goes to 0; in_ready goes to 1; busy goes to 0.
  - Reset mid-operation discards all partial results. No output glitches to 1 during reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a clk edge with in_valid && in_ready:
    - Latch a_reg = in_a.
    - Latch b_reg = in_sub ? ~in_b : in_b.
    - Set carry_reg = in_sub and idx = 0.
    - Clear the sum register and go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, the slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry_reg.
  - At the edge, the 4-bit sum is written into sum_reg[4*idx+:4] and the slice carry-out into carry_reg; idx increments.
  - When idx == NIBBLES-1 at the edge, the final nibble is written, then:
    - out_carry = final slice carry-out.
    - out_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (new sum MSB != a_reg[WIDTH-1]).
    - Go to DONE.
- Latency: out_valid is high exactly NIBBLES edges after the accepting edge (4 for WIDTH = 16). RUN duration is fixed and independent of data.
- DONE:
  - out_valid = 1; out_sum, out_carry and out_ovf are stable.
  - Hold indefinitely while out_ready = 0 (backpressure).
  - On an edge with out_ready = 1, go to IDLE. out_valid drops and in_ready rises after that edge. No same-cycle re-accept, so there is at most one result in flight.
- in_valid while not in_ready is ignored; the source must hold its operands.
- Operand inputs are sampled only at the accepting edge. Later changes to in_a, in_b or in_sub do not affect the operation in flight.
- out_ready outside DONE has no effect.
- idx width: $clog2(NIBBLES). idx wraps to 0 on leaving RUN.

Decomposition:
- Shared package adder_pkg holds:
  - NIBBLE_W = 4.
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE (2-bit).
- One sub-module: adder4_cin, a combinational 4-bit adder with a carry-in (a, b, cin -> sum[3:0], cout). The existing 4-bit adder has no carry-in, so it cannot chain nibbles. adder_seq_ctrl instantiates exactly one adder4_cin.

Test Plan:
- WIDTH = 16, add 0x00FF + 0x0001, out_ready held 1 -> out_valid 4 cycles after accept; out_sum = 0x0100, out_carry = 0, out_ovf = 0; in_ready high again the cycle after handoff.
- Add 0xFFFF + 0x0001 -> out_sum = 0x0000, out_carry = 1, out_ovf = 0. Add 0x7FFF + 0x0001 -> out_sum = 0x8000, out_carry = 0, out_ovf = 1.
- Sub 0x0005 - 0x0007 -> out_sum = 0xFFFE, out_carry = 0 (borrow), out_ovf = 0. Sub 0x8000 - 0x0001 -> out_sum = 0x7FFF, out_carry = 1, out_ovf = 1.
- Backpressure:
  - out_ready = 0 for 10 cycles after out_valid -> outputs stable, in_ready = 0.
  - Operand changes on in_a/in_b/in_valid during that window are ignored.
  - Result is released on the first out_ready = 1 edge.
- Reset: assert rst_n = 0 mid-RUN (after 2 nibbles) -> immediately out_valid = 0, in_ready = 1, out_sum = 0. The next operation 0x1234 + 0x1111 returns 0x2345.
- Back-to-back: 3 operations with in_valid held and new operands presented each time in_ready is high -> each result is correct, with one idle cycle between handoff and the next accept.
